hyper_ram_emu: RTL and testbench
================================

# hyper_ram_emu

Behavioural-but-synthesizable HyperRAM device emulator for exercising the HyperBus controller (`wb_hyper`) in simulation and on hardware loopback. It connects directly to the controller's pin-side signals. It decodes 6-byte command/address phases, applies configured initial latency, and services memory and register reads and writes. Everything is oversampled in a single system clock domain.

## Interface
- `MEM_WORDS`, 1024: memory depth in 16-bit words; addresses wrap modulo depth (power of two).
- `CR0_DEFAULT`, 16'h8F1F: CR0 value after reset (latency 6, fixed 2x).
- `ID0`, 16'h0C81; `ID1`, 16'h0001: identification register values.
- `wb_clk_i  in  1`: emulator clock, ≥4× hb_clk frequency.
- `wb_rst_i  in  1`: reset; synchronous, active-high.
- `hb_clk_o  in  1`: HyperBus clock from controller.
- `hb_cs_o  in  1`: chip select, active low.
- `hb_rst_o  in  1`: device reset, active low.
- `hb_dq_o  in  8`: controller data.
- `hb_dq_dir  in  1`: 1 = controller drives DQ.
- `hb_rwds_o  in  1`: controller RWDS; during writes this is the byte mask (1 = masked).
- `hb_rwds_dir  in  1`: 1 = controller drives RWDS.
- `hb_dq_i  out  8`: emulator read data.
- `hb_rwds_i  out  1`: emulator RWDS (latency indicator / read strobe).

## Operation
- Inputs are registered once, and hb_clk is registered twice. An "edge" is any change of the registered hb_clk while `hb_cs_o`=0; each edge transfers one byte.
- States: IDLE → CA → (LAT) → WR | RD | REGWR → IDLE.
- IDLE: on `hb_cs_o` falling, enter CA with edge count 0, and drive `hb_rwds_i` = CR0[3] (1 = 2x latency).
- CA: shift `hb_dq_o` MSB-first on 6 edges to form CA[47:0].
  - CA[47] = read; CA[46] = register space; CA[45] = linear burst (wrapped bursts are treated as linear).
  - Word address = {CA[44:16], CA[2:0]} mod `MEM_WORDS`.
- After CA:
  - Register write (CA[47]=0, CA[46]=1) goes to REGWR with zero latency.
  - Everything else goes to LAT.
- Latency code from CR0[7:4]: 0000=5, 0001=6, 1110=3, 1111=4 clocks; other codes = 6.
  - LAT waits 2·L edges, or 4·L edges if CR0[3]=1.
- WR: byte pairs are MSB first. Byte k is written unless `hb_rwds_o`=1 on that edge. After each pair the word address increments.
- RD: on each edge, drive the next byte on `hb_dq_i` (MSB of word first) and toggle `hb_rwds_i`. The address increments after every second byte.
- Register reads map by word address:
  - bit11=1 with bit0=0 → CR0; bit11=1 with bit0=1 → CR1 (reads 16'hFFC1).
  - Otherwise bit0 selects ID0/ID1.
- REGWR: 2 bytes MSB-first.
  - Address bit11=1 with bit0=0 updates CR0. All other register writes are ignored.
- `hb_cs_o` high at any edge count aborts to IDLE. A partial word is discarded and `hb_dq_i`/`hb_rwds_i` go to 0.
- `hb_rst_o`=0 behaves like `wb_rst_i`. Memory contents are preserved; CR0 is restored to default.
- The `*_dir` inputs are only used to gate sampling: `hb_dq_o` is ignored when `hb_dq_dir`=0.

## Timing
- Reset: state IDLE, `hb_dq_i`=0, `hb_rwds_i`=0, CR0=`CR0_DEFAULT`.
- Edge detection latency is 3 `wb_clk_i` cycles. The controller must hold DQ/RWDS stable ≥3 `wb_clk_i` cycles after each hb_clk edge; the 90° clock offset satisfies this at ≥4× oversampling.
- Read data updates 2 `wb_clk_i` cycles after the detected edge and is held until the next edge.
- Memory writes commit on the cycle the second byte of a word is captured.
- Simultaneous CS rise and an edge: the abort wins and the byte is discarded.

## Structure
- Package `hyper_ram_emu_pkg`: state enum, CA field bit positions, `CR0_DEFAULT`, ID constants, latency-decode function.
- Sub-module `hyper_ram_emu_mem`: single-port `MEM_WORDS`×16 RAM with 2-bit byte enables and registered read.

## Test plan
- Reset, then read register CR0 → 16'h8F1F with `hb_rwds_i`=1 during CA.
- REGWR CR0=16'h8FE4, then read back → 16'h8FE4. A subsequent memory read starts data after 3 clocks (6 edges) and `hb_rwds_i`=0 during CA.
- Write bytes 12 34 56 78 at word 0, then read 2 words → bytes 12 34 56 78.
- Linear burst write of 01..0F,00 (16 bytes) at 0, then burst read → identical sequence with RWDS toggling each byte.
- Masked write of AA BB with `hb_rwds_o`=1 on the 2nd byte over 16'h1234 → reads 16'hAA34.
- CS raised after 3 CA bytes, then new read at 0 → prior data intact and outputs 0 during the abort. Pulsing `hb_rst_o` low restores CR0 to 16'h8F1F while memory is unchanged.

Source files
------------

// File: rtl/hyper_ram_emu_pkg.sv
// Shared types and constants for the HyperRAM device emulator.
// Holds the FSM encoding, CA field positions, register values and latency decode.
package hyper_ram_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WR,
    ST_RD,
    ST_REGWR
  } state_e;

  localparam int CA_RD      = 47;
  localparam int CA_REG     = 46;
  localparam int CA_LIN     = 45;
  localparam int CA_ROW_HI  = 44;
  localparam int CA_ROW_LO  = 16;
  localparam int CA_COL_HI  = 2;
  localparam int REG_SEL    = 11;

  localparam logic [15:0] CR0_DEFAULT_VAL = 16'h8F1F;
  localparam logic [15:0] ID0_VAL         = 16'h0C81;
  localparam logic [15:0] ID1_VAL         = 16'h0001;
  localparam logic [15:0] CR1_VAL         = 16'hFFC1;

  // Initial latency in hb_clk cycles from CR0[7:4]; unknown codes fall back to 6.
  function automatic logic [2:0] lat_clocks(input logic [3:0] code);
    case (code)
      4'h0:    return 3'd5;
      4'h1:    return 3'd6;
      4'hE:    return 3'd3;
      4'hF:    return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

endpackage

// File: rtl/hyper_ram_emu_mem.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module hyper_ram_emu_mem #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata_q
);

  logic [15:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
    if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
    rdata_q <= mem[addr];
  end

endmodule

// File: rtl/hyper_ram_emu.sv
// HyperRAM device emulator: oversamples the controller pins, decodes CA,
// applies initial latency and services memory/register reads and writes.
module hyper_ram_emu
  import hyper_ram_emu_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [15:0] CR0_DEFAULT = CR0_DEFAULT_VAL,
  parameter logic [15:0] ID0         = ID0_VAL,
  parameter logic [15:0] ID1         = ID1_VAL
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       hb_clk_o,
  input  logic       hb_cs_o,
  input  logic       hb_rst_o,
  input  logic [7:0] hb_dq_o,
  input  logic       hb_dq_dir,
  input  logic       hb_rwds_o,
  input  logic       hb_rwds_dir,
  output logic [7:0] hb_dq_i,
  output logic       hb_rwds_i
);

  localparam int AW = $clog2(MEM_WORDS);

  // Input capture; hb_clk gets an extra stage so edges are seen after DQ settles.
  logic       cs_q, cs_prev_q, hb_rst_q, dq_dir_q, rwds_q, rwds_dir_q;
  logic [7:0] dq_q;
  logic       clk_s1_q, clk_s2_q, clk_s3_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cs_q       <= 1'b1;
      cs_prev_q  <= 1'b1;
      hb_rst_q   <= 1'b1;
      dq_q       <= '0;
      dq_dir_q   <= 1'b0;
      rwds_q     <= 1'b0;
      rwds_dir_q <= 1'b0;
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_s3_q   <= 1'b0;
    end else begin
      cs_q       <= hb_cs_o;
      cs_prev_q  <= cs_q;
      hb_rst_q   <= hb_rst_o;
      dq_q       <= hb_dq_o;
      dq_dir_q   <= hb_dq_dir;
      rwds_q     <= hb_rwds_o;
      rwds_dir_q <= hb_rwds_dir;
      clk_s1_q   <= hb_clk_o;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
    end
  end

  logic        rst;
  logic        edge_det, mask_in;
  logic [7:0]  dq_in, lat_edges;
  logic [2:0]  lat_clk;
  logic [47:0] ca_shift;
  logic [15:0] reg_rdata, mem_rdata, rd_word;
  logic        unused_ca;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [39:0] ca_q, ca_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d, reg_q, reg_d, byte_sel_q, byte_sel_d;
  logic [7:0]  byte0_q, byte0_d, dq_i_q, dq_i_d;
  logic        mask0_q, mask0_d, rd_pend_q, rd_pend_d, rwds_i_q, rwds_i_d;
  logic [15:0] cr0_q, cr0_d;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;

  assign rst       = wb_rst_i | ~hb_rst_q;
  assign edge_det  = (clk_s2_q ^ clk_s3_q) & ~cs_q;
  assign dq_in     = dq_dir_q ? dq_q : 8'h00;
  assign mask_in   = rwds_q & rwds_dir_q;
  assign ca_shift  = {ca_q, dq_in};
  assign unused_ca = ^{ca_shift[CA_LIN], ca_shift[CA_ROW_LO-1:CA_COL_HI+1]};
  assign lat_clk   = lat_clocks(cr0_q[7:4]);
  assign lat_edges = cr0_q[3] ? {3'b000, lat_clk, 2'b00} : {4'b0000, lat_clk, 1'b0};
  assign reg_rdata = addr_q[REG_SEL] ? (addr_q[0] ? CR1_VAL : cr0_q)
                                     : (addr_q[0] ? ID1 : ID0);
  assign rd_word   = reg_q ? reg_rdata : mem_rdata;
  assign mem_wdata = {byte0_q, dq_in};
  assign mem_be    = {~mask0_q, ~mask_in};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ca_d       = ca_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    reg_d      = reg_q;
    byte_sel_d = byte_sel_q;
    byte0_d    = byte0_q;
    mask0_d    = mask0_q;
    rd_pend_d  = 1'b0;
    dq_i_d     = dq_i_q;
    rwds_i_d   = rwds_i_q;
    cr0_d      = cr0_q;
    mem_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs_q) begin
          dq_i_d   = 8'h00;
          rwds_i_d = 1'b0;
        end else if (cs_prev_q) begin
          state_d  = ST_CA;
          cnt_d    = '0;
          dq_i_d   = 8'h00;
          rwds_i_d = cr0_q[3];
        end
      end
      ST_CA: if (edge_det) begin
        ca_d  = ca_shift[39:0];
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd5) begin
          addr_d     = {ca_shift[CA_ROW_HI:CA_ROW_LO], ca_shift[CA_COL_HI:0]};
          rd_d       = ca_shift[CA_RD];
          reg_d      = ca_shift[CA_REG];
          cnt_d      = '0;
          byte_sel_d = 1'b0;
          state_d    = (!ca_shift[CA_RD] && ca_shift[CA_REG]) ? ST_REGWR : ST_LAT;
        end
      end
      ST_LAT: if (edge_det) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == lat_edges - 8'd1) begin
          cnt_d   = '0;
          state_d = rd_q ? ST_RD : ST_WR;
        end
      end
      ST_WR: if (edge_det) begin
        byte_sel_d = ~byte_sel_q;
        if (!byte_sel_q) begin
          byte0_d = dq_in;
          mask0_d = mask_in;
        end else begin
          mem_we = 1'b1;
          addr_d = addr_q + 32'd1;
        end
      end
      ST_RD: begin
        // Edge is acted on one cycle later so the registered RAM word is settled.
        rd_pend_d = edge_det;
        if (rd_pend_q) begin
          dq_i_d     = byte_sel_q ? rd_word[7:0] : rd_word[15:8];
          rwds_i_d   = ~rwds_i_q;
          byte_sel_d = ~byte_sel_q;
          if (byte_sel_q) addr_d = addr_q + 32'd1;
        end
      end
      ST_REGWR: if (edge_det) begin
        byte_sel_d = ~byte_sel_q;
        if (!byte_sel_q) begin
          byte0_d = dq_in;
        end else begin
          if (addr_q[REG_SEL] && !addr_q[0]) cr0_d = {byte0_q, dq_in};
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // CS high wins over any edge seen in the same cycle.
    if (state_q != ST_IDLE && cs_q) begin
      state_d    = ST_IDLE;
      dq_i_d     = 8'h00;
      rwds_i_d   = 1'b0;
      rd_pend_d  = 1'b0;
      byte_sel_d = 1'b0;
      cr0_d      = cr0_q;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ca_q       <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      reg_q      <= 1'b0;
      byte_sel_q <= 1'b0;
      byte0_q    <= '0;
      mask0_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      dq_i_q     <= '0;
      rwds_i_q   <= 1'b0;
      cr0_q      <= CR0_DEFAULT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ca_q       <= ca_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      reg_q      <= reg_d;
      byte_sel_q <= byte_sel_d;
      byte0_q    <= byte0_d;
      mask0_q    <= mask0_d;
      rd_pend_q  <= rd_pend_d;
      dq_i_q     <= dq_i_d;
      rwds_i_q   <= rwds_i_d;
      cr0_q      <= cr0_d;
    end
  end

  hyper_ram_emu_mem #(.WORDS(MEM_WORDS)) u_mem (
    .clk     (wb_clk_i),
    .we      (mem_we),
    .be      (mem_be),
    .addr    (addr_q[AW-1:0]),
    .wdata   (mem_wdata),
    .rdata_q (mem_rdata)
  );

  assign hb_dq_i   = dq_i_q;
  assign hb_rwds_i = rwds_i_q;

endmodule

// File: tb/tb_hyper_ram_emu.sv
// Directed plus randomized bench for hyper_ram_emu against a word-array model.
module tb_hyper_ram_emu;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic       hb_clk_o = 1'b0;
  logic       hb_cs_o = 1'b1;
  logic       hb_rst_o = 1'b1;
  logic [7:0] hb_dq_o = 8'h00;
  logic       hb_dq_dir = 1'b0;
  logic       hb_rwds_o = 1'b0;
  logic       hb_rwds_dir = 1'b0;
  logic [7:0] hb_dq_i;
  logic       hb_rwds_i;

  hyper_ram_emu dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .hb_clk_o    (hb_clk_o),
    .hb_cs_o     (hb_cs_o),
    .hb_rst_o    (hb_rst_o),
    .hb_dq_o     (hb_dq_o),
    .hb_dq_dir   (hb_dq_dir),
    .hb_rwds_o   (hb_rwds_o),
    .hb_rwds_dir (hb_rwds_dir),
    .hb_dq_i     (hb_dq_i),
    .hb_rwds_i   (hb_rwds_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] model [1024];
  bit          known [1024];
  logic [15:0] cr0m;
  logic        exp_rwds;
  logic [7:0]  wq [$];
  logic        mq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One hb_clk transition with DQ/RWDS set up before and held well after it.
  task automatic hb_edge(input logic [7:0] d, input logic m, input logic drv);
    @(negedge wb_clk_i);
    hb_dq_o = d; hb_rwds_o = m; hb_dq_dir = drv; hb_rwds_dir = drv;
    repeat (2) @(negedge wb_clk_i);
    hb_clk_o = ~hb_clk_o;
    repeat (6) @(negedge wb_clk_i);
  endtask

  task automatic cs_lo();
    @(negedge wb_clk_i); hb_cs_o = 1'b0;
    repeat (3) @(negedge wb_clk_i);
  endtask

  task automatic cs_hi();
    @(negedge wb_clk_i); hb_cs_o = 1'b1; hb_dq_dir = 1'b0; hb_rwds_dir = 1'b0;
    repeat (4) @(negedge wb_clk_i);
  endtask

  function automatic int lat_edges_m();
    int l;
    case (cr0m[7:4])
      4'h0: l = 5;  4'h1: l = 6;  4'hE: l = 3;  4'hF: l = 4;
      default: l = 6;
    endcase
    return l * (cr0m[3] ? 4 : 2);
  endfunction

  function automatic logic [15:0] exp_word(input logic [31:0] a, input logic rg);
    if (!rg) return model[a % 1024];
    if (a[11]) return a[0] ? 16'hFFC1 : cr0m;
    return a[0] ? 16'h0001 : 16'h0C81;
  endfunction

  task automatic send_ca(input logic rd, input logic rg, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, rg, 1'b1, a[31:3], 13'd0, a[2:0]};
    exp_rwds = cr0m[3];
    for (int i = 0; i < 6; i++) hb_edge(ca[47-8*i -: 8], 1'b0, 1'b1);
    chk("ca_rwds", {31'd0, hb_rwds_i}, {31'd0, exp_rwds});
  endtask

  task automatic latency();
    int n;
    n = lat_edges_m();
    for (int i = 0; i < n; i++) hb_edge(8'h00, 1'b0, 1'b0);
    chk("lat_quiet", {23'd0, hb_dq_i, hb_rwds_i}, {23'd0, 8'h00, exp_rwds});
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic rg, input int nw);
    logic [15:0] w;
    logic [7:0]  b;
    cs_lo();
    send_ca(1'b1, rg, a);
    latency();
    for (int i = 0; i < nw; i++) begin
      w = exp_word(a + i, rg);
      for (int k = 0; k < 2; k++) begin
        hb_edge(8'h00, 1'b0, 1'b0);
        exp_rwds = ~exp_rwds;
        b = (k == 0) ? w[15:8] : w[7:0];
        chk(rg ? "reg_rd" : "mem_rd", {23'd0, hb_dq_i, hb_rwds_i}, {23'd0, b, exp_rwds});
      end
    end
    cs_hi();
    chk("idle_out", {23'd0, hb_dq_i, hb_rwds_i}, 32'd0);
  endtask

  // Burst write from wq/mq; a trailing odd byte is aborted by CS and never lands.
  task automatic wr_burst(input logic [31:0] a);
    int idx;
    cs_lo();
    send_ca(1'b0, 1'b0, a);
    latency();
    for (int i = 0; i < wq.size(); i++) hb_edge(wq[i], mq[i], 1'b1);
    cs_hi();
    for (int p = 0; p < wq.size() / 2; p++) begin
      idx = int'((a + p) % 1024);
      if (!mq[2*p])   model[idx][15:8] = wq[2*p];
      if (!mq[2*p+1]) model[idx][7:0]  = wq[2*p+1];
      known[idx] = 1'b1;
    end
  endtask

  task automatic regwr(input logic [31:0] a, input logic [15:0] v);
    cs_lo();
    send_ca(1'b0, 1'b1, a);
    hb_edge(v[15:8], 1'b0, 1'b1);
    hb_edge(v[7:0], 1'b0, 1'b1);
    cs_hi();
    if (a[11] && !a[0]) cr0m = v;
  endtask

  initial begin
    logic [3:0]  codes [5];
    logic [31:0] ra;
    int          nw;
    codes = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
    cr0m = 16'h8F1F;
    repeat (4) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    chk("reset_out", {23'd0, hb_dq_i, hb_rwds_i}, 32'd0);

    rd_burst(32'h800, 1'b1, 1);
    rd_burst(32'h000, 1'b1, 1);
    rd_burst(32'h001, 1'b1, 1);
    rd_burst(32'h801, 1'b1, 1);
    regwr(32'h801, 16'h1234);
    regwr(32'h000, 16'h5555);
    rd_burst(32'h800, 1'b1, 1);
    regwr(32'h800, 16'h8FE4);
    rd_burst(32'h800, 1'b1, 1);

    wq = '{8'h12, 8'h34, 8'h56, 8'h78}; mq = '{0, 0, 0, 0};
    wr_burst(32'h0);
    rd_burst(32'h0, 1'b0, 2);
    wq = '{8'hAA, 8'hBB}; mq = '{0, 1};
    wr_burst(32'h0);
    rd_burst(32'h0, 1'b0, 1);

    wq.delete(); mq.delete();
    for (int i = 1; i <= 16; i++) begin wq.push_back(8'(i % 16)); mq.push_back(1'b0); end
    wr_burst(32'h0);
    rd_burst(32'h0, 1'b0, 8);

    // Abort during CA, then during the second word of a write.
    cs_lo();
    hb_edge(8'h20, 1'b0, 1'b1); hb_edge(8'h00, 1'b0, 1'b1); hb_edge(8'h00, 1'b0, 1'b1);
    cs_hi();
    chk("abort_out", {23'd0, hb_dq_i, hb_rwds_i}, 32'd0);
    wq = '{8'h9A, 8'hBC, 8'hDE}; mq = '{0, 0, 0};
    wr_burst(32'h0);
    rd_burst(32'h0, 1'b0, 8);

    @(negedge wb_clk_i); hb_rst_o = 1'b0;
    repeat (3) @(negedge wb_clk_i); hb_rst_o = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    cr0m = 16'h8F1F;
    rd_burst(32'h800, 1'b1, 1);
    rd_burst(32'h0, 1'b0, 2);

    for (int it = 0; it < 6; it++) begin
      regwr(32'h800, {8'h8F, codes[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 3'b111});
      ra = 32'($urandom_range(0, 4095));
      nw = $urandom_range(1, 4);
      wq.delete(); mq.delete();
      for (int i = 0; i < 2 * nw; i++) begin
        wq.push_back(8'($urandom_range(0, 255)));
        mq.push_back(known[(ra + i / 2) % 1024] ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      wr_burst(ra);
      rd_burst(ra, 1'b0, nw);
    end

    // Burst crossing the top of memory wraps to word 0.
    wq = '{8'hC3, 8'h3C, 8'h5A, 8'hA5}; mq = '{0, 0, 0, 0};
    wr_burst(32'h13FF);
    rd_burst(32'h3FF, 1'b0, 2);
    rd_burst(32'h0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
